thumb_it_cond_unit: RTL and testbench

Condition unit for the Thumb execute stage: decides whether the current 16-bit instruction takes effect (o_met), from the APSR flags and the IT-block state it tracks. It handles the IT instruction (ITSTATE load and advance), per-slot Then/Else conditions, conditional branches B<c>, and illegal-encoding detection. A parameter bounds the IT block length. It sits between decode and the writeback/branch-commit logic.

---
 rtl/thumb_it_cond_unit.sv | 104 ++++++++++
 tb/tb_thumb_it_cond_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/thumb_it_cond_unit.sv
// Thumb execute-stage condition unit: tracks ITSTATE and decides whether the current
// instruction executes, plus illegal-encoding detection for IT and B<c>.
module thumb_it_cond_unit #(
    parameter int MAX_IT_LEN = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_ir,
    input  logic [3:0]  i_apsr,
    input  logic        i_valid,
    input  logic        i_flush,
    output logic        o_met,
    output logic        o_illegal,
    output logic        o_in_it,
    output logic [3:0]  o_it_cond,
    output logic [2:0]  o_it_remaining
);

    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [2:0] MAX_LEN = 3'(MAX_IT_LEN);

    logic [7:0] itstate;
    logic [7:0] itstate_nxt;
    logic       in_it;
    logic       is_it;
    logic       is_bcond;
    logic       it_legal;
    logic [2:0] it_len;
    logic [3:0] cc;

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] apsr);
        logic n, z, c, v;
        n = apsr[3];
        z = apsr[2];
        c = apsr[1];
        v = apsr[0];
        case (cond)
            4'h0:    cond_pass = z;
            4'h1:    cond_pass = !z;
            4'h2:    cond_pass = c;
            4'h3:    cond_pass = !c;
            4'h4:    cond_pass = n;
            4'h5:    cond_pass = !n;
            4'h6:    cond_pass = v;
            4'h7:    cond_pass = !v;
            4'h8:    cond_pass = c && !z;
            4'h9:    cond_pass = !c || z;
            4'hA:    cond_pass = (n == v);
            4'hB:    cond_pass = (n != v);
            4'hC:    cond_pass = !z && (n == v);
            4'hD:    cond_pass = z || (n != v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    // Length encoded by an IT mask; the lowest set bit marks the end of the block.
    function automatic logic [2:0] mask_len(input logic [3:0] mask);
        if (mask[0])      mask_len = 3'd4;
        else if (mask[1]) mask_len = 3'd3;
        else if (mask[2]) mask_len = 3'd2;
        else if (mask[3]) mask_len = 3'd1;
        else              mask_len = 3'd0;
    endfunction

    always_comb begin
        in_it    = |itstate[3:0];
        is_it    = (i_ir[15:8] == 8'hBF) && (|i_ir[3:0]);
        is_bcond = (i_ir[15:12] == 4'hD) && (i_ir[11:8] <= 4'hD);
        it_len   = mask_len(i_ir[3:0]);
        it_legal = is_it && (i_ir[7:4] != 4'hF) && (it_len <= MAX_LEN);

        if (in_it)         cc = itstate[7:4];
        else if (is_bcond) cc = i_ir[11:8];
        else               cc = COND_AL;

        o_illegal      = in_it ? (is_it || is_bcond) : (is_it && !it_legal);
        o_met          = !o_illegal && cond_pass(cc, i_apsr);
        o_in_it        = in_it;
        o_it_cond      = in_it ? itstate[7:4] : COND_AL;
        o_it_remaining = mask_len(itstate[3:0]);
    end

    // Flush beats a load; slots are consumed even when the condition fails.
    always_comb begin
        itstate_nxt = itstate;
        if (i_flush) begin
            itstate_nxt = 8'h00;
        end else if (i_valid) begin
            if (in_it) begin
                if (itstate[2:0] == 3'b000) itstate_nxt = 8'h00;
                else                        itstate_nxt = {itstate[7:5], itstate[3:0], 1'b0};
            end else if (it_legal) begin
                itstate_nxt = i_ir[7:0];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) itstate <= 8'h00;
        else       itstate <= itstate_nxt;
    end

endmodule

// File: tb/tb_thumb_it_cond_unit.sv
// Randomized bench for thumb_it_cond_unit: two instances (MAX_IT_LEN 4 and 2) checked
// against a slot-list reference model of IT blocks.
module tb_thumb_it_cond_unit;

    logic        i_clk;
    logic        i_rst;
    logic [15:0] i_ir;
    logic [3:0]  i_apsr;
    logic        i_valid;
    logic        i_flush;

    logic       m4, il4, ii4;
    logic [3:0] c4;
    logic [2:0] r4;
    logic       m2, il2, ii2;
    logic [3:0] c2;
    logic [2:0] r2;

    int total = 0;
    int bad   = 0;

    // Reference: an IT block is a list of slot conditions plus a read position.
    int blk_cond[2][4];
    int blk_len[2];
    int blk_pos[2];

    thumb_it_cond_unit #(.MAX_IT_LEN(4)) dut4 (
        .i_clk(i_clk), .i_rst(i_rst), .i_ir(i_ir), .i_apsr(i_apsr),
        .i_valid(i_valid), .i_flush(i_flush),
        .o_met(m4), .o_illegal(il4), .o_in_it(ii4),
        .o_it_cond(c4), .o_it_remaining(r4)
    );

    thumb_it_cond_unit #(.MAX_IT_LEN(2)) dut2 (
        .i_clk(i_clk), .i_rst(i_rst), .i_ir(i_ir), .i_apsr(i_apsr),
        .i_valid(i_valid), .i_flush(i_flush),
        .o_met(m2), .o_illegal(il2), .o_in_it(ii2),
        .o_it_cond(c2), .o_it_remaining(r2)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic bit ref_pass(input int cond, input logic [3:0] f);
        bit n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond)
            0:  return z;
            1:  return !z;
            2:  return c;
            3:  return !c;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return c && !z;
            9:  return !c || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int ref_len(input logic [3:0] m);
        for (int k = 0; k < 4; k++)
            if (m[k]) return 4 - k;
        return 0;
    endfunction

    function automatic bit ref_is_it(input logic [15:0] ir);
        return (ir[15:8] == 8'hBF) && (ir[3:0] != 4'h0);
    endfunction

    function automatic bit ref_is_bcond(input logic [15:0] ir);
        return (ir[15:12] == 4'hD) && (int'(ir[11:8]) <= 13);
    endfunction

    function automatic int max_of(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    task automatic ref_clear(input int d);
        blk_len[d] = 0;
        blk_pos[d] = 0;
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            int  rem, cc, e_cond;
            bit  in_blk, e_ill, e_met;
            int  g_met, g_ill, g_in, g_cond, g_rem;
            rem    = blk_len[d] - blk_pos[d];
            in_blk = (rem > 0);
            if (in_blk)                  cc = blk_cond[d][blk_pos[d]];
            else if (ref_is_bcond(i_ir)) cc = int'(i_ir[11:8]);
            else                         cc = 14;
            if (in_blk) e_ill = ref_is_it(i_ir) || ref_is_bcond(i_ir);
            else        e_ill = ref_is_it(i_ir) && ((i_ir[7:4] == 4'hF) || (ref_len(i_ir[3:0]) > max_of(d)));
            e_met  = !e_ill && ref_pass(cc, i_apsr);
            e_cond = in_blk ? cc : 14;
            g_met  = (d == 0) ? int'(m4)  : int'(m2);
            g_ill  = (d == 0) ? int'(il4) : int'(il2);
            g_in   = (d == 0) ? int'(ii4) : int'(ii2);
            g_cond = (d == 0) ? int'(c4)  : int'(c2);
            g_rem  = (d == 0) ? int'(r4)  : int'(r2);
            chk($sformatf("met_max%0d ir=%h", max_of(d), i_ir), g_met, int'(e_met));
            chk($sformatf("illegal_max%0d ir=%h", max_of(d), i_ir), g_ill, int'(e_ill));
            chk($sformatf("in_it_max%0d", max_of(d)), g_in, int'(in_blk));
            chk($sformatf("it_cond_max%0d", max_of(d)), g_cond, e_cond);
            chk($sformatf("remaining_max%0d", max_of(d)), g_rem, rem);
        end
    endtask

    task automatic ref_update();
        for (int d = 0; d < 2; d++) begin
            if (i_rst || i_flush) begin
                ref_clear(d);
            end else if (i_valid) begin
                if (blk_len[d] > blk_pos[d]) begin
                    blk_pos[d]++;
                    if (blk_pos[d] >= blk_len[d]) ref_clear(d);
                end else if (ref_is_it(i_ir) && (i_ir[7:4] != 4'hF) &&
                             (ref_len(i_ir[3:0]) <= max_of(d))) begin
                    int fc;
                    fc = int'(i_ir[7:4]);
                    blk_len[d] = ref_len(i_ir[3:0]);
                    blk_pos[d] = 0;
                    blk_cond[d][0] = fc;
                    for (int i = 1; i < blk_len[d]; i++)
                        blk_cond[d][i] = (fc & 14) | int'(i_ir[4 - i]);
                end
            end
        end
    endtask

    task automatic drive(input logic [15:0] ir, input logic [3:0] f, input logic v, input logic fl);
        i_ir    = ir;
        i_apsr  = f;
        i_valid = v;
        i_flush = fl;
        #2;
        check_all();
    endtask

    task automatic tick();
        @(posedge i_clk);
        ref_update();
        #1;
    endtask

    initial begin
        i_rst = 1'b1; i_ir = 16'h0; i_apsr = 4'h0; i_valid = 1'b0; i_flush = 1'b0;
        ref_clear(0);
        ref_clear(1);
        repeat (2) tick();

        // Reset state and plain decode
        drive(16'h4000, 4'h0, 1'b1, 1'b0);
        chk("rst_met", m4, 1); chk("rst_in_it", ii4, 0);
        chk("rst_cond", c4, 14); chk("rst_rem", r4, 0);
        drive(16'hD012, 4'h0, 1'b0, 1'b0); chk("beq_z0", m4, 0);
        drive(16'hD012, 4'h4, 1'b0, 1'b0); chk("beq_z1", m4, 1);
        i_rst = 1'b0;

        // ITTE EQ
        drive(16'hBF06, 4'h4, 1'b1, 1'b0); chk("itte_met", m4, 1); tick();
        drive(16'h4000, 4'h4, 1'b1, 1'b0);
        chk("itte_c0", c4, 0); chk("itte_m0", m4, 1); chk("itte_r0", r4, 3); tick();
        drive(16'h4000, 4'h4, 1'b1, 1'b0);
        chk("itte_c1", c4, 0); chk("itte_m1", m4, 1); chk("itte_r1", r4, 2); tick();
        drive(16'h4000, 4'h4, 1'b1, 1'b0);
        chk("itte_c2", c4, 1); chk("itte_m2", m4, 0); chk("itte_r2", r4, 1); tick();
        drive(16'h4000, 4'h4, 1'b0, 1'b0); chk("itte_done", ii4, 0);

        // ITT NE with stalls between slots
        drive(16'hBF1C, 4'h0, 1'b1, 1'b0); tick();
        drive(16'h4000, 4'h0, 1'b1, 1'b0); chk("stall_c0", c4, 1); chk("stall_m0", m4, 1); tick();
        for (int i = 0; i < 3; i++) begin
            drive(16'h4000, 4'h4, 1'b0, 1'b0); chk("stall_hold_c", c4, 1); chk("stall_hold_r", r4, 1);
            tick();
        end
        drive(16'h4000, 4'h4, 1'b1, 1'b0); chk("stall_c1", c4, 1); chk("stall_m1", m4, 0); tick();

        // Flush mid-block
        drive(16'hBFC1, 4'h0, 1'b1, 1'b0); tick();
        drive(16'h4000, 4'h0, 1'b1, 1'b0); chk("gt_r0", r4, 4); tick();
        drive(16'h4000, 4'h0, 1'b1, 1'b1); tick();
        drive(16'h4000, 4'h0, 1'b0, 1'b0); chk("flush_in_it", ii4, 0); chk("flush_cond", c4, 14);

        // Illegal encodings inside a block
        drive(16'hBF04, 4'h4, 1'b1, 1'b0); tick();
        drive(16'hD012, 4'h4, 1'b1, 1'b0);
        chk("bcc_in_it_ill", il4, 1); chk("bcc_in_it_met", m4, 0); chk("bcc_in_it_rem", r4, 2); tick();
        drive(16'hBF08, 4'h4, 1'b1, 1'b0);
        chk("it_in_it_ill", il4, 1); chk("it_in_it_met", m4, 0); chk("it_in_it_rem", r4, 1); tick();
        drive(16'h4000, 4'h4, 1'b0, 1'b0); chk("ill_done", ii4, 0);

        // Block longer than MAX_IT_LEN
        drive(16'hBF01, 4'h4, 1'b1, 1'b0); chk("max2_ill", il2, 1); chk("max4_ok", il4, 0); tick();
        drive(16'h4000, 4'h4, 1'b0, 1'b0); chk("max2_in_it", ii2, 0); chk("max4_rem", r4, 4);
        drive(16'h4000, 4'h4, 1'b0, 1'b1); tick();

        // Asynchronous reset between edges
        drive(16'hBF08, 4'h4, 1'b1, 1'b0); tick();
        drive(16'h4000, 4'h4, 1'b0, 1'b0); chk("arst_pre", ii4, 1);
        #1 i_rst = 1'b1;
        #1;
        ref_clear(0);
        ref_clear(1);
        chk("arst_in_it", ii4, 0); chk("arst_cond", c4, 14);
        tick();
        i_rst = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] ir;
            int sel;
            sel = $urandom_range(0, 9);
            ir  = 16'($urandom);
            if (sel <= 2)      ir[15:8] = 8'hBF;
            else if (sel <= 4) ir[15:12] = 4'hD;
            drive(ir, 4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
